g2_chain_walker: RTL and testbench

- Controller directly upstream of each G2 table instance (search_G2table).
- Accepts a lookup request (packet tuple plus head index), walks the G2 table's linked entry chain via next_index until a srcIP hit, null pointer or hop limit, then returns ruleID and hit status.
- Also serialises update writes into the table.
- Owns the table's search_index/tupleData/we/din inputs and consumes its match/ruleID/next_index outputs.

---
 rtl/g2_pkg.sv | 42 ++++
 rtl/g2_walk_stats.sv | 37 +++
 rtl/g2_chain_walker.sv | 220 ++++++++++++++++++++++
 tb/tb_g2_chain_walker.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g2_pkg.sv
// g2_pkg: shared definitions for the G2 table chain walker.
//   - default widths of table index, packet tuple and table entry
//   - end-of-chain pointer constant
//   - walker FSM state encoding
//   - bit positions of the next_index and ruleID fields inside an entry,
//     plus small accessor functions for them
package g2_pkg;

    localparam int G2_INDEX_BIT_LEN    = 11;
    localparam int G2_PACKET_BIT_LEN   = 104;
    localparam int G2_ENTRY_DATA_WIDTH = 60;
    localparam int G2_MAX_HOPS         = 8;

    localparam logic [G2_INDEX_BIT_LEN-1:0] G2_NULL_INDEX = '1;

    // Entry layout: next_index occupies the top 11 bits, ruleID the next 11.
    localparam int G2_NEXT_MSB = G2_ENTRY_DATA_WIDTH - 1;
    localparam int G2_NEXT_LSB = G2_ENTRY_DATA_WIDTH - 11;
    localparam int G2_RULE_MSB = G2_ENTRY_DATA_WIDTH - 12;
    localparam int G2_RULE_LSB = G2_ENTRY_DATA_WIDTH - 22;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        LOOKUP = 3'd2,
        EVAL   = 3'd3,
        RESP   = 3'd4
    } g2_state_t;

    function automatic logic [G2_INDEX_BIT_LEN-1:0] g2_entry_next(
        input logic [G2_ENTRY_DATA_WIDTH-1:0] entry
    );
        return entry[G2_NEXT_MSB:G2_NEXT_LSB];
    endfunction

    function automatic logic [G2_INDEX_BIT_LEN-1:0] g2_entry_rule(
        input logic [G2_ENTRY_DATA_WIDTH-1:0] entry
    );
        return entry[G2_RULE_MSB:G2_RULE_LSB];
    endfunction

endpackage

// File: rtl/g2_walk_stats.sv
// g2_walk_stats: wrapping 32-bit event counters for the chain walker.
// Only instantiated when G2_WALK_STATS_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears counters)
//   fire            result handshake (res_valid & res_ready) this cycle
//   hit, overflow   result status qualifying the handshake
//   stat_lookups    handshakes seen
//   stat_hits       handshakes carrying a hit
//   stat_overflows  handshakes carrying a hop-limit overflow
module g2_walk_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic        hit,
    input  logic        overflow,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_overflows
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups   <= '0;
            stat_hits      <= '0;
            stat_overflows <= '0;
        end else if (fire) begin
            stat_lookups <= stat_lookups + 32'd1;
            if (hit) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (overflow) begin
                stat_overflows <= stat_overflows + 32'd1;
            end
        end
    end

endmodule

// File: rtl/g2_chain_walker.sv
// g2_chain_walker: controller in front of one G2 table (search_G2table).
// Walks the table's linked chain from a head index until a srcIP hit, a
// null next pointer, or MAX_HOPS reads, then returns ruleID/hit status.
// Also serialises single-cycle update writes into the table.
//
// Optional feature: define G2_WALK_STATS_EN to add the stat_lookups,
// stat_hits and stat_overflows counter outputs.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      lookup request handshake, req_head/req_tuple
//   wr_valid/wr_ready        update write handshake, wr_index/wr_data
//   res_valid/res_ready      result handshake, res_hit/res_ruleID/
//                            res_hops/res_overflow
//   search_index, tupleData, we, din   drive the table
//   match, ruleID, next_index          table outputs, valid one cycle
//                                      after search_index is sampled
//   fsm_state                walker state, for observation
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge; ready never depends on valid of the same channel.
module g2_chain_walker
    import g2_pkg::*;
#(
    parameter int INDEX_BIT_LEN    = G2_INDEX_BIT_LEN,
    parameter int PACKET_BIT_LEN   = G2_PACKET_BIT_LEN,
    parameter int ENTRY_DATA_WIDTH = G2_ENTRY_DATA_WIDTH,
    parameter int MAX_HOPS         = G2_MAX_HOPS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [INDEX_BIT_LEN-1:0]    req_head,
    input  logic [PACKET_BIT_LEN-1:0]   req_tuple,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [INDEX_BIT_LEN-1:0]    wr_index,
    input  logic [ENTRY_DATA_WIDTH-1:0] wr_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_hit,
    output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
    output logic [3:0]                  res_hops,
    output logic                        res_overflow,
    output logic [INDEX_BIT_LEN-1:0]    search_index,
    output logic [PACKET_BIT_LEN-1:0]   tupleData,
    output logic                        we,
    output logic [ENTRY_DATA_WIDTH-1:0] din,
    input  logic                        match,
    input  logic [INDEX_BIT_LEN-1:0]    ruleID,
    input  logic [INDEX_BIT_LEN-1:0]    next_index,
    output g2_state_t                   fsm_state
`ifdef G2_WALK_STATS_EN
    ,
    output logic [31:0]                 stat_lookups,
    output logic [31:0]                 stat_hits,
    output logic [31:0]                 stat_overflows
`endif
);

    localparam logic [INDEX_BIT_LEN-1:0] NULL_INDEX = '1;
    localparam logic [3:0]               MAX_HOPS_W = 4'(MAX_HOPS);

    // hops is a 4-bit counter, so the limit must fit in it.
    if (MAX_HOPS < 1 || MAX_HOPS > 15) begin : g_bad_max_hops
        $error("g2_chain_walker: MAX_HOPS must be in 1..15");
    end

    g2_state_t state;
    g2_state_t state_next;

    // idx_r only changes when entering LOOKUP or WRITE, so search_index
    // holds its last value in every other state.
    logic [INDEX_BIT_LEN-1:0]    idx_r;
    logic [PACKET_BIT_LEN-1:0]   tuple_r;
    logic [ENTRY_DATA_WIDTH-1:0] din_r;
    logic [3:0]                  hops;
    logic                        hit_r;
    logic                        ovf_r;
    logic [INDEX_BIT_LEN-1:0]    rule_r;
    logic [3:0]                  res_hops_r;

    logic head_null;
    logic chain_end;
    logic hop_limit;

    assign head_null = (req_head == NULL_INDEX);
    assign chain_end = (next_index == NULL_INDEX);
    assign hop_limit = (hops == MAX_HOPS_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        we         = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                // Writes win over lookups when both are offered.
                wr_ready  = !rst;
                req_ready = !rst && !wr_valid;
                if (wr_valid) begin
                    state_next = WRITE;
                end else if (req_valid) begin
                    state_next = head_null ? RESP : LOOKUP;
                end
            end
            WRITE: begin
                we         = 1'b1;
                state_next = IDLE;
            end
            LOOKUP: begin
                state_next = EVAL;
            end
            EVAL: begin
                if (match || chain_end || hop_limit) begin
                    state_next = RESP;
                end else begin
                    state_next = LOOKUP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= '0;
            tuple_r    <= '0;
            din_r      <= '0;
            hops       <= '0;
            hit_r      <= 1'b0;
            ovf_r      <= 1'b0;
            rule_r     <= '0;
            res_hops_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        idx_r <= wr_index;
                        din_r <= wr_data;
                    end else if (req_valid) begin
                        hops       <= '0;
                        hit_r      <= 1'b0;
                        ovf_r      <= 1'b0;
                        rule_r     <= '0;
                        res_hops_r <= '0;
                        // A null head is an immediate miss; the table is
                        // never addressed, so its inputs are left alone.
                        if (!head_null) begin
                            idx_r   <= req_head;
                            tuple_r <= req_tuple;
                        end
                    end
                end
                LOOKUP: begin
                    if (hops != 4'hF) begin
                        hops <= hops + 4'd1;
                    end
                end
                EVAL: begin
                    res_hops_r <= hops;
                    if (match) begin
                        hit_r  <= 1'b1;
                        rule_r <= ruleID;
                    end else if (chain_end) begin
                        hit_r <= 1'b0;
                    end else if (hop_limit) begin
                        ovf_r <= 1'b1;
                    end else begin
                        idx_r <= next_index;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign search_index = idx_r;
    assign tupleData    = tuple_r;
    assign din          = din_r;
    assign res_hit      = hit_r;
    assign res_ruleID   = rule_r;
    assign res_hops     = res_hops_r;
    assign res_overflow = ovf_r;
    assign fsm_state    = state;

`ifdef G2_WALK_STATS_EN
    g2_walk_stats u_stats (
        .clk            (clk),
        .rst            (rst),
        .fire           (res_valid && res_ready),
        .hit            (hit_r),
        .overflow       (ovf_r),
        .stat_lookups   (stat_lookups),
        .stat_hits      (stat_hits),
        .stat_overflows (stat_overflows)
    );
`endif

endmodule

// File: tb/tb_g2_chain_walker.sv
// tb_g2_chain_walker: directed + small random bench for g2_chain_walker.
// Contains a behavioural G2 table (registered read, write on we) whose
// entries are {next_index[59:49], ruleID[48:38], srcIP[37:6], pad[5:0]};
// a match is srcIP equal to tuple bits [103:72].
module tb_g2_chain_walker;
    import g2_pkg::*;

    localparam int IW        = G2_INDEX_BIT_LEN;
    localparam int PW        = G2_PACKET_BIT_LEN;
    localparam int EW        = G2_ENTRY_DATA_WIDTH;
    localparam int MAX_HOPS  = 8;
    localparam logic [31:0] SRC  = 32'hC0A8_0001;
    localparam logic [31:0] NSRC = 32'h0BAD_0BAD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_head = '0;
    logic [PW-1:0] req_tuple = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [IW-1:0] wr_index = '0;
    logic [EW-1:0] wr_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_hit;
    logic [IW-1:0] res_ruleID;
    logic [3:0]    res_hops;
    logic          res_overflow;
    logic [IW-1:0] search_index;
    logic [PW-1:0] tupleData;
    logic          we;
    logic [EW-1:0] din;
    logic          match = 1'b0;
    logic [IW-1:0] ruleID = '0;
    logic [IW-1:0] next_index = '0;
    g2_state_t     fsm_state;
`ifdef G2_WALK_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_overflows;
`endif

    g2_chain_walker dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_head     (req_head),
        .req_tuple    (req_tuple),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_index     (wr_index),
        .wr_data      (wr_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_hit      (res_hit),
        .res_ruleID   (res_ruleID),
        .res_hops     (res_hops),
        .res_overflow (res_overflow),
        .search_index (search_index),
        .tupleData    (tupleData),
        .we           (we),
        .din          (din),
        .match        (match),
        .ruleID       (ruleID),
        .next_index   (next_index),
        .fsm_state    (fsm_state)
`ifdef G2_WALK_STATS_EN
        ,
        .stat_lookups   (stat_lookups),
        .stat_hits      (stat_hits),
        .stat_overflows (stat_overflows)
`endif
    );

    // ---------------- table model ----------------
    logic [EW-1:0] mem [0:(1<<IW)-1];
    logic          tbl_clear = 1'b0;
    logic          ld_en = 1'b0;
    logic [IW-1:0] ld_addr = '0;
    logic [EW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (tbl_clear) begin
            for (int i = 0; i < (1 << IW); i++) mem[i] <= {G2_NULL_INDEX, 11'd0, 32'd0, 6'd0};
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (we) begin
            mem[search_index] <= din;
        end
        match      <= (mem[search_index][37:6] == tupleData[103:72]);
        ruleID     <= g2_entry_rule(mem[search_index]);
        next_index <= g2_entry_next(mem[search_index]);
    end

    // Table addresses actually read during walks.
    logic [IW-1:0] idx_log[$];
    always @(posedge clk) begin
        if (fsm_state == LOOKUP) idx_log.push_back(search_index);
    end

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];     // {hit, ruleID, hops, overflow}
    int checks = 0;
    int errors = 0;
    int exp_lookups = 0, exp_hits = 0, exp_ovfs = 0;

    function automatic logic [EW-1:0] mk_entry(input logic [IW-1:0] nxt, input logic [IW-1:0] rule,
                                               input logic [31:0] src);
        return {nxt, rule, src, 6'd0};
    endfunction

    function automatic logic [16:0] mk_exp(input logic hit, input logic [IW-1:0] rule,
                                           input logic [3:0] hops, input logic ovf);
        return {hit, rule, hops, ovf};
    endfunction

    function automatic logic [PW-1:0] mk_tuple(input logic [31:0] src);
        return {src, 72'h11_2233_4455_6677_8899};
    endfunction

    // Reference walk over the table contents.
    function automatic logic [16:0] model_walk(input logic [IW-1:0] head, input logic [31:0] src);
        logic [IW-1:0] idx;
        logic [EW-1:0] e;
        idx = head;
        if (head == G2_NULL_INDEX) return mk_exp(1'b0, '0, 4'd0, 1'b0);
        for (int h = 1; h <= MAX_HOPS; h++) begin
            e = mem[idx];
            if (e[37:6] == src) return mk_exp(1'b1, g2_entry_rule(e), 4'(h), 1'b0);
            if (g2_entry_next(e) == G2_NULL_INDEX) return mk_exp(1'b0, '0, 4'(h), 1'b0);
            if (h == MAX_HOPS) return mk_exp(1'b0, '0, 4'(h), 1'b1);
            idx = g2_entry_next(e);
        end
        return mk_exp(1'b0, '0, 4'd0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IW-1:0] a, input logic [EW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [16:0] e);
        check({tag, "_hit"},  64'(res_hit),      64'(e[16]));
        check({tag, "_rule"}, 64'(res_ruleID),   64'(e[15:5]));
        check({tag, "_hops"}, 64'(res_hops),     64'(e[4:1]));
        check({tag, "_ovf"},  64'(res_overflow), 64'(e[0]));
    endtask

    // Issue one lookup, wait for its result, optionally stall res_ready for
    // `hold` cycles, then complete the handshake and score the result.
    task automatic lookup(input string tag, input logic [IW-1:0] head, input logic [PW-1:0] tup,
                          input logic [16:0] e, input int hold);
        int cyc;
        logic [16:0] got_exp;
        req_valid = 1'b1; req_head = head; req_tuple = tup;
        cyc = 0;
        while (!req_ready && cyc < 20) begin tick(); cyc++; end
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 64) begin tick(); cyc++; end
        check({tag, "_latency"}, 64'(cyc), 64'(1 + 2 * int'(e[4:1])));
        if (hold > 0) begin
            repeat (hold) tick();
            check({tag, "_held_valid"}, 64'(res_valid), 64'd1);
            check_result({tag, "_held"}, e);
        end
        res_ready = 1'b1;
        got_exp = exp_q.pop_front();
        check_result(tag, got_exp);
        exp_lookups++;
        if (got_exp[16]) exp_hits++;
        if (got_exp[0]) exp_ovfs++;
        tick();
        res_ready = 1'b0;
        check({tag, "_res_cleared"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [EW-1:0] d_new;
        int cnt;

        // Reset state (rst held high)
        tbl_clear = 1'b1;
        repeat (3) tick();
        tbl_clear = 1'b0;
        check("rst_res_valid",    64'(res_valid),    64'd0);
        check("rst_we",           64'(we),           64'd0);
        check("rst_req_ready",    64'(req_ready),    64'd0);
        check("rst_wr_ready",     64'(wr_ready),     64'd0);
        check("rst_search_index", 64'(search_index), 64'd0);
        check("rst_din",          64'(din),          64'd0);
        check("rst_res_hops",     64'(res_hops),     64'd0);

        // Table contents
        load(11'd5,  mk_entry(G2_NULL_INDEX, 11'h02A, SRC));
        load(11'd3,  mk_entry(11'd9,  11'd0, NSRC));
        load(11'd9,  mk_entry(11'd12, 11'd0, NSRC));
        load(11'd12, mk_entry(G2_NULL_INDEX, 11'h101, SRC));
        load(11'd20, mk_entry(11'd21, 11'h033, NSRC));
        load(11'd21, mk_entry(G2_NULL_INDEX, 11'h055, NSRC));
        load(11'd1,  mk_entry(11'd2, 11'h011, NSRC));
        load(11'd2,  mk_entry(11'd1, 11'h022, NSRC));

        rst = 1'b0;
        #1;
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_wr_ready",  64'(wr_ready),  64'd1);

        // Single-hop hit
        lookup("single_hit", 11'd5, mk_tuple(SRC), mk_exp(1'b1, 11'h02A, 4'd1, 1'b0), 0);

        // Three-hop chain hit and the addresses it reads
        idx_log.delete();
        lookup("chain_hit", 11'd3, mk_tuple(SRC), mk_exp(1'b1, 11'h101, 4'd3, 1'b0), 0);
        check("chain_reads", 64'(idx_log.size()), 64'd3);
        if (idx_log.size() == 3) begin
            check("chain_idx0", 64'(idx_log[0]), 64'd3);
            check("chain_idx1", 64'(idx_log[1]), 64'd9);
            check("chain_idx2", 64'(idx_log[2]), 64'd12);
        end

        // Null pointer ends the chain: miss with ruleID 0
        lookup("null_end", 11'd20, mk_tuple(SRC), mk_exp(1'b0, 11'd0, 4'd2, 1'b0), 0);

        // Null head: immediate miss, no table reads
        idx_log.delete();
        lookup("null_head", G2_NULL_INDEX, mk_tuple(SRC), mk_exp(1'b0, 11'd0, 4'd0, 1'b0), 0);
        check("null_head_reads", 64'(idx_log.size()), 64'd0);

        // Cyclic chain stopped by hop limit, with result backpressure
        lookup("hop_limit", 11'd1, mk_tuple(SRC), mk_exp(1'b0, 11'd0, 4'd8, 1'b1), 5);

        // Write has priority over a simultaneous lookup
        d_new = mk_entry(G2_NULL_INDEX, 11'h03C, SRC);
        wr_valid = 1'b1; wr_index = 11'd7; wr_data = d_new;
        req_valid = 1'b1; req_head = 11'd7; req_tuple = mk_tuple(SRC);
        #1;
        check("wp_wr_ready",  64'(wr_ready),  64'd1);
        check("wp_req_ready", 64'(req_ready), 64'd0);
        tick();
        wr_valid = 1'b0;
        check("wp_we",           64'(we),           64'd1);
        check("wp_search_index", 64'(search_index), 64'd7);
        check("wp_din",          64'(din),          64'(d_new));
        check("wp_req_blocked",  64'(req_ready),    64'd0);
        tick();
        check("wp_we_one_cycle", 64'(we), 64'd0);
        lookup("wp_lookup", 11'd7, mk_tuple(SRC), mk_exp(1'b1, 11'h03C, 4'd1, 1'b0), 0);

        // Random chains over a small region, expectations from the model
        for (int i = 0; i < 8; i++) begin
            logic [IW-1:0] nxt;
            nxt = ($urandom_range(0, 3) == 0) ? G2_NULL_INDEX : IW'(100 + $urandom_range(0, 7));
            load(IW'(100 + i), mk_entry(nxt, IW'($urandom_range(1, 2000)),
                                        ($urandom_range(0, 2) == 0) ? SRC : NSRC));
        end
        for (int i = 0; i < 6; i++) begin
            logic [IW-1:0] h;
            h = IW'(100 + $urandom_range(0, 7));
            lookup("random", h, mk_tuple(SRC), model_walk(h, SRC), $urandom_range(0, 2));
        end

`ifdef G2_WALK_STATS_EN
        check("stat_lookups",   64'(stat_lookups),   64'(exp_lookups));
        check("stat_hits",      64'(stat_hits),      64'(exp_hits));
        check("stat_overflows", 64'(stat_overflows), 64'(exp_ovfs));
`endif

        // Reset during LOOKUP drops the request silently
        req_valid = 1'b1; req_head = 11'd1; req_tuple = mk_tuple(SRC);
        tick();
        req_valid = 1'b0;
        check("rw_in_lookup", 64'(fsm_state), 64'(LOOKUP));
        rst = 1'b1;
        tick();
        check("rw_state_idle", 64'(fsm_state), 64'(IDLE));
        check("rw_res_valid",  64'(res_valid), 64'd0);
        check("rw_we",         64'(we),        64'd0);
        rst = 1'b0;
        exp_lookups = 0; exp_hits = 0; exp_ovfs = 0;
        res_ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (res_valid) cnt++;
        end
        res_ready = 1'b0;
        check("rw_no_response", 64'(cnt),       64'd0);
        check("rw_req_ready",   64'(req_ready), 64'd1);
`ifdef G2_WALK_STATS_EN
        check("rw_stat_cleared", 64'(stat_lookups), 64'(exp_lookups));
`endif
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
